mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM; sequences the shared datapath (PC, IR, regfile,
//  imm extender, ALU, unified memory port) through IF/ID/EX/MEM/WB one instr at a time.
//  Decodes opcode/funct from IR and drives every datapath select and strobe,
//  including the extender sign/zero select (ext_sorz).
//  Sits between IR and datapath muxes in the CPU core; memory accesses are
//  handshaked so slow memories stall the FSM.
// PARAMETERS
//  RESET_STATE  4'd0  FSM state entered on reset (S_IF); fixed, not to be overridden
// PORTS
//  clk          in   1  core clock, rising edge
//  rst          in   1  async, active-high reset
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (valid in S_BR)
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_write     out  1  load PC unconditionally
//  pc_write_cond out 1  load PC if branch taken (beq: zero, bne: !zero)
//  branch_ne    out  1  1 = bne polarity for pc_write_cond
//  pc_source    out  2  0 ALU, 1 ALUOut, 2 jump target, 3 rs (jr)
//  iord         out  1  mem addr: 0 PC, 1 ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  load IR
//  reg_write    out  1  regfile write enable
//  reg_dst      out  2  0 rt, 1 rd, 2 r31
//  mem_to_reg   out  2  0 ALUOut, 1 MDR, 2 PC (jal)
//  alu_src_a    out  1  0 PC, 1 rs
//  alu_src_b    out  2  0 rt, 1 const 4, 2 imm_32, 3 imm_32<<2
//  alu_ctrl     out  4  0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOR 6 SLT 7 SLL 8 SRL 9 LUI
//  ext_sorz     out  1  extender select: 1 sign, 0 zero
//  illegal_op   out  1  1-cycle pulse on undecodable opcode/funct
// BEHAVIOUR
//  - Outputs Moore-decoded from state (+mem_ready gating below); while rst=1 state=S_IF
//    and every output forced 0. First fetch request on first clk edge after rst falls.
//  - States: S_IF S_ID S_MADDR S_MRD S_MWB S_MWR S_EXR S_WBR S_EXI S_WBI S_BR S_J S_JAL S_JR.
//  - S_IF: mem_read=1,iord=0,alu_src_a=0,alu_src_b=1,ADD,pc_source=0; ir_write=pc_write=mem_ready;
//    stay while !mem_ready, else ->S_ID.
//  - S_ID: alu_src_b=3,ADD,ext_sorz=1 (branch target to ALUOut). Next by opcode:
//    lw/sw->S_MADDR; R(0x00)->S_EXR, funct 0x08->S_JR; addi/slti/andi/ori/xori/lui->S_EXI;
//    beq/bne->S_BR; j->S_J; jal->S_JAL; else illegal_op=1, ->S_IF.
//  - S_MADDR: alu_src_a=1,alu_src_b=2,ADD,ext_sorz=1; lw->S_MRD, sw->S_MWR.
//  - S_MRD: mem_read=1,iord=1; hold until mem_ready, then ->S_MWB. S_MWB: reg_write=1,reg_dst=0,mem_to_reg=1 ->S_IF.
//  - S_MWR: mem_write=1,iord=1; hold until mem_ready, then ->S_IF.
//  - S_EXR: alu_src_a=1,alu_src_b=0, alu_ctrl by funct: 20/21 ADD,22/23 SUB,24 AND,25 OR,26 XOR,
//    27 NOR,2A SLT,00 SLL,02 SRL; other funct -> illegal_op, ->S_IF. S_WBR: reg_write,reg_dst=1 ->S_IF.
//  - S_EXI: alu_src_a=1,alu_src_b=2; addi ADD s, slti SLT s, andi AND z, ori OR z, xori XOR z,
//    lui LUI z (s/z = ext_sorz 1/0). S_WBI: reg_write,reg_dst=0,mem_to_reg=0 ->S_IF.
//  - S_BR: alu_src_a=1,alu_src_b=0,SUB,pc_write_cond=1,pc_source=1,branch_ne=(bne) ->S_IF.
//  - S_J: pc_write,pc_source=2. S_JAL: as S_J plus reg_write,reg_dst=2,mem_to_reg=2. S_JR: pc_write,pc_source=3. All ->S_IF.
//  - ext_sorz is 0 in every state not listed above. mem_read and mem_write never both 1.
//  - mem_ready outside S_IF/S_MRD/S_MWR ignored. Opcode/funct sampled only in S_ID/S_EXR/S_EXI
//    (IR stable there). rst mid-access drops mem_read/mem_write same cycle (async).
//  - CPI: R/I 4, lw 5, sw 4, branch/jump 3, each + memory wait cycles.
// STRUCTURE
//  - mc_ctrl_defs.vh (shared include): state codes, opcode/funct constants, alu_ctrl
//    codes, pc_source/reg_dst/mem_to_reg encodings.
//  - Sub-module mc_alu_dec: combinational funct/opcode -> alu_ctrl, ext_sorz, legal flag.
//  - Top: state register (async rst), next-state logic, output decode.
// TESTING
//  - Reset: rst=1 mid-S_MRD -> all outputs 0 same cycle; release -> S_IF, mem_read=1, iord=0.
//  - Fetch stall: mem_ready low 3 cycles in S_IF -> ir_write/pc_write 0 throughout, pulse once on ready.
//  - addi (op 0x08) then ori (op 0x0D) -> S_EXI ext_sorz=1 ALU=0, then ext_sorz=0 ALU=3; reg_write in WB, 4 cycles each.
//  - lw with 2 wait cycles -> S_MRD held 3 cycles, iord=1; S_MWB reg_write=1 mem_to_reg=1; total 7 cycles.
//  - beq zero=1 / bne zero=1 -> pc_write_cond=1, branch_ne=0 / 1, pc_source=1; back to S_IF after 3 cycles.
//  - opcode 0x3F and R funct 0x3F -> illegal_op 1-cycle pulse, no reg_write/mem_write, return to S_IF.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the multi-cycle MIPS controller (states, opcodes,
//           funct codes, ALU operations, datapath mux selects, control bundle).
// Latency : n/a (types and constants only). Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_EXI   = 4'd8,
    S_WBI   = 4'd9,
    S_BR    = 4'd10,
    S_J     = 4'd11,
    S_JAL   = 4'd12,
    S_JR    = 4'd13
  } state_t;

  // Fixed reset state; not a module parameter so it cannot be overridden.
  localparam logic [3:0] RESET_STATE = 4'd0;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  // pc_source
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  // reg_dst
  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  // mem_to_reg
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // alu_src_b
  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMS2 = 2'd3;

  // Complete set of datapath controls driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       ext_sorz;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Purpose : combinational ALU decode; R-type funct or I-type opcode -> alu_ctrl,
//           extender sign/zero select and a legal flag.
// Latency : 0 cycles (pure combinational). Backpressure: none.
// Ports   : i_rtype selects funct decode (1) or opcode decode (0); i_opcode, i_funct from IR;
//           o_alu_ctrl ALU op, o_ext_sorz 1=sign/0=zero extend, o_legal 1 when decodable.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic       i_rtype,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_ext_sorz,
  output logic       o_legal
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_ext_sorz = 1'b0;
    o_legal    = 1'b1;
    if (i_rtype) begin
      case (i_funct)
        FN_ADD, FN_ADDU: o_alu_ctrl = ALU_ADD;
        FN_SUB, FN_SUBU: o_alu_ctrl = ALU_SUB;
        FN_AND:          o_alu_ctrl = ALU_AND;
        FN_OR:           o_alu_ctrl = ALU_OR;
        FN_XOR:          o_alu_ctrl = ALU_XOR;
        FN_NOR:          o_alu_ctrl = ALU_NOR;
        FN_SLT:          o_alu_ctrl = ALU_SLT;
        FN_SLL:          o_alu_ctrl = ALU_SLL;
        FN_SRL:          o_alu_ctrl = ALU_SRL;
        default:         o_legal    = 1'b0;
      endcase
    end else begin
      // Arithmetic immediates sign-extend; logical immediates and lui zero-extend.
      case (i_opcode)
        OP_ADDI: begin o_alu_ctrl = ALU_ADD; o_ext_sorz = 1'b1; end
        OP_SLTI: begin o_alu_ctrl = ALU_SLT; o_ext_sorz = 1'b1; end
        OP_ANDI: o_alu_ctrl = ALU_AND;
        OP_ORI:  o_alu_ctrl = ALU_OR;
        OP_XORI: o_alu_ctrl = ALU_XOR;
        OP_LUI:  o_alu_ctrl = ALU_LUI;
        default: o_legal    = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose : multi-cycle MIPS control FSM sequencing IF/ID/EX/MEM/WB on a shared datapath.
// Latency : outputs decoded from the state register; CPI R/I 4, lw 5, sw 4, br/j 3 (+mem waits).
// Backpressure: mem_ready low holds S_IF/S_MRD/S_MWR; rst forces every output low at once.
// Ports   : clk/rst; opcode/funct from IR; zero ALU flag; mem_ready memory handshake;
//           outputs are the PC, memory, IR, regfile, extender and ALU controls.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       ext_sorz,
  output logic       illegal_op
);

  state_t     r_state;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic [3:0] w_dec_alu;
  logic       w_dec_ext;
  logic       w_dec_legal;
  logic       w_is_exr;

  // Branch resolution (zero vs. branch_ne) happens in the datapath's PC-enable
  // gate, so the flag is not needed here.
  logic       w_unused_zero;
  assign w_unused_zero = zero;

  assign w_is_exr = (r_state == S_EXR);

  mc_alu_dec u_alu_dec (
    .i_rtype    (w_is_exr),
    .i_opcode   (opcode),
    .i_funct    (funct),
    .o_alu_ctrl (w_dec_alu),
    .o_ext_sorz (w_dec_ext),
    .o_legal    (w_dec_legal)
  );

  // State register and next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_IF:    if (mem_ready) r_state <= S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:                  r_state <= (funct == FN_JR) ? S_JR : S_EXR;
            OP_LW, OP_SW:              r_state <= S_MADDR;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI:   r_state <= S_EXI;
            OP_BEQ, OP_BNE:            r_state <= S_BR;
            OP_J:                      r_state <= S_J;
            OP_JAL:                    r_state <= S_JAL;
            default:                   r_state <= S_IF;
          endcase
        end
        S_MADDR: r_state <= (opcode == OP_SW) ? S_MWR : S_MRD;
        S_MRD:   if (mem_ready) r_state <= S_MWB;
        S_MWR:   if (mem_ready) r_state <= S_IF;
        S_EXR:   r_state <= w_dec_legal ? S_WBR : S_IF;
        S_EXI:   r_state <= S_WBI;
        default: r_state <= S_IF;
      endcase
    end
  end

  // Moore output decode; only S_IF's IR/PC strobes look at mem_ready.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_IF: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_ID: begin
        // Speculative branch target into ALUOut while the opcode is decoded.
        w_ctrl.alu_src_b = SRCB_IMMS2;
        w_ctrl.ext_sorz  = 1'b1;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
          OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL: w_ctrl.illegal_op = 1'b0;
          default:                                       w_ctrl.illegal_op = 1'b1;
        endcase
      end
      S_MADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_sorz  = 1'b1;
      end
      S_MRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = RD_RT;
        w_ctrl.mem_to_reg = M2R_MDR;
      end
      S_MWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_EXR: begin
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_src_b  = SRCB_RT;
        w_ctrl.alu_ctrl   = w_dec_alu;
        w_ctrl.illegal_op = ~w_dec_legal;
      end
      S_WBR: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = RD_RD;
      end
      S_EXI: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_ctrl  = w_dec_alu;
        w_ctrl.ext_sorz  = w_dec_ext;
      end
      S_WBI: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = RD_RT;
        w_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BR: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RT;
        w_ctrl.alu_ctrl      = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCS_ALUOUT;
        w_ctrl.branch_ne     = (opcode == OP_BNE);
      end
      S_J: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.pc_source  = PCS_JUMP;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = RD_R31;
        w_ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCS_RS;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset blanks outputs combinationally so an in-flight memory request drops
  // in the same cycle rst rises, not at the next edge.
  assign w_out = rst ? '0 : w_ctrl;

  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign branch_ne     = w_out.branch_ne;
  assign pc_source     = w_out.pc_source;
  assign iord          = w_out.iord;
  assign mem_read      = w_out.mem_read;
  assign mem_write     = w_out.mem_write;
  assign ir_write      = w_out.ir_write;
  assign reg_write     = w_out.reg_write;
  assign reg_dst       = w_out.reg_dst;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign alu_ctrl      = w_out.alu_ctrl;
  assign ext_sorz      = w_out.ext_sorz;
  assign illegal_op    = w_out.illegal_op;

endmodule
